// File: rtl/acc_seq_if.sv
// Handshake and control bundle between the accumulator sequencer and its surroundings.
// master: sequencer side (drives memory request and datapath controls).
// slave : memory / datapath side (drives run, opcode, zero flag and ack).
// Ports (master view):
//   in : run_i, ir_op_i[OPW], acc_zero_i, mem_ack_i
//   out: mem_req_o, mem_we_o, addr_sel_o, acc_oe_o, ld_ir_o, pc_inc_o, pc_load_o,
//        en_da_o, alu_op_o[3], halted_o, bus_err_o, illegal_o
interface acc_seq_if #(
    parameter int OPW = 4
);
    logic           run_i;
    logic [OPW-1:0] ir_op_i;
    logic           acc_zero_i;
    logic           mem_ack_i;

    logic           mem_req_o;
    logic           mem_we_o;
    logic           addr_sel_o;
    logic           acc_oe_o;
    logic           ld_ir_o;
    logic           pc_inc_o;
    logic           pc_load_o;
    logic           en_da_o;
    logic [2:0]     alu_op_o;
    logic           halted_o;
    logic           bus_err_o;
    logic           illegal_o;

    modport master (
        input  run_i, ir_op_i, acc_zero_i, mem_ack_i,
        output mem_req_o, mem_we_o, addr_sel_o, acc_oe_o, ld_ir_o, pc_inc_o,
               pc_load_o, en_da_o, alu_op_o, halted_o, bus_err_o, illegal_o
    );

    modport slave (
        output run_i, ir_op_i, acc_zero_i, mem_ack_i,
        input  mem_req_o, mem_we_o, addr_sel_o, acc_oe_o, ld_ir_o, pc_inc_o,
               pc_load_o, en_da_o, alu_op_o, halted_o, bus_err_o, illegal_o
    );
endinterface

// File: rtl/acc_seq_ctrl.sv
// Fetch/decode/execute sequencer for the single-accumulator 8-bit ISA.
// Latency: fetch and memory phases last 1+ack-wait cycles, decode is exactly 1 cycle.
// Backpressure: mem_req is held until mem_ack; TIMEOUT un-acked cycles -> sticky bus_err + HALT.
// Ports: clk (rising edge), clr (async active-low reset), bus (acc_seq_if.master, see interface).
module acc_seq_ctrl #(
    parameter int OPW     = 4,
    parameter int TIMEOUT = 15
) (
    input  logic      clk,
    input  logic      clr,
    acc_seq_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_MEM_RD, S_MEM_WR, S_HALT
    } state_t;

    localparam logic [OPW-1:0] OP_NOP = OPW'(0);
    localparam logic [OPW-1:0] OP_LDA = OPW'(1);
    localparam logic [OPW-1:0] OP_STA = OPW'(2);
    localparam logic [OPW-1:0] OP_ADD = OPW'(3);
    localparam logic [OPW-1:0] OP_SUB = OPW'(4);
    localparam logic [OPW-1:0] OP_AND = OPW'(5);
    localparam logic [OPW-1:0] OP_OR  = OPW'(6);
    localparam logic [OPW-1:0] OP_JMP = OPW'(7);
    localparam logic [OPW-1:0] OP_JZ  = OPW'(8);
    localparam logic [OPW-1:0] OP_HLT = OPW'(15);

    localparam logic [2:0] ALU_PASS = 3'b000;
    localparam logic [2:0] ALU_ADD  = 3'b001;
    localparam logic [2:0] ALU_SUB  = 3'b010;
    localparam logic [2:0] ALU_AND  = 3'b011;
    localparam logic [2:0] ALU_OR   = 3'b100;

    // Value of wait_q in the last permitted un-acked request cycle.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t     state_q, state_d;
    state_t     after_ins;
    logic [7:0] wait_q, wait_d;
    logic       bus_err_q, bus_err_d;
    logic [2:0] alu_q, alu_d;

    // State register; clr drops straight to IDLE so all decoded outputs fall at once.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q   <= S_IDLE;
            wait_q    <= '0;
            bus_err_q <= 1'b0;
            alu_q     <= ALU_PASS;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            bus_err_q <= bus_err_d;
            alu_q     <= alu_d;
        end
    end

    // Next-state logic. wait_d defaults to 0 so the counter is clear on
    // entry to every request state and only counts while a request stalls.
    always_comb begin
        state_d   = state_q;
        wait_d    = '0;
        bus_err_d = bus_err_q;
        alu_d     = alu_q;
        // Completing an instruction returns to IDLE instead of FETCH when run is low.
        after_ins = bus.run_i ? S_FETCH : S_IDLE;
        case (state_q)
            S_IDLE: begin
                if (bus.run_i) state_d = S_FETCH;
            end
            S_FETCH, S_MEM_RD, S_MEM_WR: begin
                // An ack in the final permitted cycle still beats the timeout.
                if (bus.mem_ack_i) begin
                    state_d = (state_q == S_FETCH) ? S_DECODE : after_ins;
                end else if (wait_q == WAIT_LAST) begin
                    bus_err_d = 1'b1;
                    state_d   = S_HALT;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            S_DECODE: begin
                case (bus.ir_op_i)
                    OP_HLT: state_d = S_HALT;
                    OP_LDA: begin alu_d = ALU_PASS; state_d = S_MEM_RD; end
                    OP_ADD: begin alu_d = ALU_ADD;  state_d = S_MEM_RD; end
                    OP_SUB: begin alu_d = ALU_SUB;  state_d = S_MEM_RD; end
                    OP_AND: begin alu_d = ALU_AND;  state_d = S_MEM_RD; end
                    OP_OR:  begin alu_d = ALU_OR;   state_d = S_MEM_RD; end
                    OP_STA: state_d = S_MEM_WR;
                    default: state_d = after_ins;  // NOP, JMP, JZ, undefined
                endcase
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode. alu_op comes from a register latched in DECODE so it
    // stays stable for the whole read even if the IR input wiggles.
    always_comb begin
        bus.mem_req_o  = 1'b0;
        bus.mem_we_o   = 1'b0;
        bus.addr_sel_o = 1'b0;
        bus.acc_oe_o   = 1'b0;
        bus.ld_ir_o    = 1'b0;
        bus.pc_inc_o   = 1'b0;
        bus.pc_load_o  = 1'b0;
        bus.en_da_o    = 1'b0;
        bus.alu_op_o   = ALU_PASS;
        bus.halted_o   = 1'b0;
        bus.illegal_o  = 1'b0;
        bus.bus_err_o  = bus_err_q;
        case (state_q)
            S_FETCH: begin
                bus.mem_req_o = 1'b1;
                bus.ld_ir_o   = bus.mem_ack_i;
                bus.pc_inc_o  = bus.mem_ack_i;
            end
            S_DECODE: begin
                case (bus.ir_op_i)
                    OP_JMP: bus.pc_load_o = 1'b1;
                    OP_JZ:  bus.pc_load_o = bus.acc_zero_i;
                    OP_NOP, OP_LDA, OP_STA, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_HLT: ;
                    default: bus.illegal_o = 1'b1;
                endcase
            end
            S_MEM_RD: begin
                bus.mem_req_o  = 1'b1;
                bus.addr_sel_o = 1'b1;
                bus.alu_op_o   = alu_q;
                bus.en_da_o    = bus.mem_ack_i;
            end
            S_MEM_WR: begin
                bus.mem_req_o  = 1'b1;
                bus.mem_we_o   = 1'b1;
                bus.addr_sel_o = 1'b1;
                bus.acc_oe_o   = 1'b1;
            end
            S_HALT:  bus.halted_o = 1'b1;
            default: ;
        endcase
    end
endmodule

// File: tb/tb_acc_seq_ctrl.sv
// Testbench for acc_seq_ctrl: bench-side memory/IR/PC responder plus a
// program-level reference model predicting counts, timing and ALU ops.
module tb_acc_seq_ctrl;
    localparam int TO = 15;

    logic clk = 1'b0;
    logic clr;

    acc_seq_if #(.OPW(4)) bus ();

    acc_seq_ctrl #(.OPW(4), .TIMEOUT(TO)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errs   = 0;

    // Program: opcode, jump target and acc_zero value seen while it executes.
    int op_a  [16];
    int tgt_a [16];
    bit z_a   [16];
    // Ack delay per memory access in program order; >= TO means never acked.
    int dly   [$];

    // Model results.
    int e_halt, e_ldir, e_pcload, e_enda, e_wr, e_ill, e_req, e_berr;
    int e_alu [$];
    // Observed event cycles, used by the directed timing checks.
    int en_cyc [$];
    int wr_cyc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errs++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int dget(input int i);
        return (i < dly.size()) ? dly[i] : 0;
    endfunction

    function automatic int alu_of(input int op);
        return (op == 1) ? 0 : op - 2;   // LDA->PASS, ADD..OR -> 1..4
    endfunction

    task automatic clear_prog();
        for (int i = 0; i < 16; i++) begin
            op_a[i] = 15; tgt_a[i] = 0; z_a[i] = 1'b0;
        end
        dly.delete();
    endtask

    // Instruction-level model: walk the program, add up cycle costs.
    task automatic predict();
        int pc = 0, ai = 0, t = 0, d, op, cur, guard = 0;
        e_ldir = 0; e_pcload = 0; e_enda = 0; e_wr = 0; e_ill = 0; e_req = 0; e_berr = 0;
        e_alu.delete();
        while (guard < 100) begin
            guard++;
            d = dget(ai); ai++;
            if (d >= TO) begin t += TO; e_req += TO; e_berr = 1; break; end
            t += d + 1; e_req += d + 1; e_ldir++;
            cur = pc; op = op_a[cur]; pc++;
            t += 1;                                  // decode
            if (op == 15) break;
            if (op == 7) begin pc = tgt_a[cur]; e_pcload++; end
            else if (op == 8) begin
                if (z_a[cur]) begin pc = tgt_a[cur]; e_pcload++; end
            end else if (op >= 1 && op <= 6) begin
                d = dget(ai); ai++;
                if (d >= TO) begin t += TO; e_req += TO; e_berr = 1; break; end
                t += d + 1; e_req += d + 1;
                if (op == 2) e_wr++;
                else begin e_enda++; e_alu.push_back(alu_of(op)); end
            end else if (op != 0) e_ill++;
        end
        e_halt = t + 1;
    endtask

    task automatic do_reset();
        bus.run_i = 1'b0; bus.mem_ack_i = 1'b0; bus.ir_op_i = '0; bus.acc_zero_i = 1'b0;
        clr = 1'b0;
        repeat (2) @(negedge clk);
        clr = 1'b1;
    endtask

    task automatic step(input logic a);
        @(negedge clk);
        bus.mem_ack_i = a;
        #1;
    endtask

    // Run the loaded program with run=1 until HALT and compare with the model.
    task automatic exec_prog(input string nm);
        int pc = 0, cur = 0, ai = 0, waited = 0, curd = 0, cyc = 0, halt_at = 0;
        bit in_acc = 1'b0;
        bit ack, rd;
        int o_ldir = 0, o_pcinc = 0, o_pcload = 0, o_enda = 0, o_wr = 0, o_ill = 0, o_req = 0;
        int o_alu [$];
        en_cyc.delete(); wr_cyc = -1;
        predict();
        do_reset();
        bus.run_i = 1'b1;
        while (halt_at == 0 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            ack = 1'b0;
            if (!bus.mem_req_o) in_acc = 1'b0;
            else begin
                if (!in_acc) begin in_acc = 1'b1; waited = 0; curd = dget(ai); ai++; end
                ack = (waited == curd);
                waited++;
                if (ack) in_acc = 1'b0;
            end
            bus.mem_ack_i = ack;
            #1;
            if (bus.halted_o) halt_at = cyc;
            o_req += int'(bus.mem_req_o);
            rd = bus.mem_req_o && bus.addr_sel_o && !bus.mem_we_o;
            chk({nm, " en_da_with_we"}, bus.en_da_o & bus.mem_we_o, 0);
            chk({nm, " alu_op"}, bus.alu_op_o, rd ? alu_of(op_a[cur]) : 0);
            chk({nm, " ld_ir_on_fetch_ack"}, bus.ld_ir_o, bus.mem_req_o & !bus.addr_sel_o & ack);
            chk({nm, " en_da_on_read_ack"}, bus.en_da_o, rd & ack);
            chk({nm, " acc_oe"}, bus.acc_oe_o, bus.mem_req_o & bus.mem_we_o);
            if (bus.illegal_o) o_ill++;
            if (bus.ld_ir_o) begin
                o_ldir++; cur = pc;
                bus.ir_op_i = 4'(op_a[cur]); bus.acc_zero_i = z_a[cur];
            end
            if (bus.pc_inc_o) begin o_pcinc++; pc++; end
            if (bus.pc_load_o) begin o_pcload++; pc = tgt_a[cur]; end
            if (bus.en_da_o) begin o_enda++; o_alu.push_back(int'(bus.alu_op_o)); en_cyc.push_back(cyc); end
            if (bus.mem_req_o && bus.mem_we_o && ack) begin o_wr++; wr_cyc = cyc; end
        end
        chk({nm, " halt_cycle"}, halt_at, e_halt);
        chk({nm, " ld_ir_count"}, o_ldir, e_ldir);
        chk({nm, " pc_inc_count"}, o_pcinc, e_ldir);
        chk({nm, " pc_load_count"}, o_pcload, e_pcload);
        chk({nm, " en_da_count"}, o_enda, e_enda);
        chk({nm, " write_count"}, o_wr, e_wr);
        chk({nm, " illegal_count"}, o_ill, e_ill);
        chk({nm, " req_cycles"}, o_req, e_req);
        chk({nm, " bus_err"}, bus.bus_err_o, e_berr);
        for (int i = 0; i < o_alu.size() && i < e_alu.size(); i++)
            chk({nm, " en_da_alu_op"}, o_alu[i], e_alu[i]);
    endtask

    initial begin
        // Asynchronous reset before any clock edge.
        bus.run_i = 1'b0; bus.mem_ack_i = 1'b0; bus.ir_op_i = '0; bus.acc_zero_i = 1'b0;
        clr = 1'b0;
        #2;
        chk("reset mem_req", bus.mem_req_o, 0);
        chk("reset halted", bus.halted_o, 0);
        chk("reset bus_err", bus.bus_err_o, 0);
        chk("reset pulses", {bus.ld_ir_o, bus.pc_inc_o, bus.pc_load_o, bus.en_da_o, bus.illegal_o}, 0);
        chk("reset alu_op", bus.alu_op_o, 0);

        // LDA, ADD, STA, HLT with single-cycle acks.
        clear_prog();
        op_a[0] = 1; op_a[1] = 3; op_a[2] = 2; op_a[3] = 15;
        exec_prog("t1");
        chk("t1 en_da_first_cycle", en_cyc.size() > 0 ? en_cyc[0] : -1, 3);
        chk("t1 en_da_second_cycle", en_cyc.size() > 1 ? en_cyc[1] : -1, 6);
        chk("t1 write_cycle", wr_cyc, 9);

        // Reset while halted clears HALT.
        clr = 1'b0; #1;
        chk("t1 halted_cleared", bus.halted_o, 0);

        // JZ taken (acc_zero=1) then JZ not taken (acc_zero=0).
        clear_prog();
        op_a[0] = 8; tgt_a[0] = 2; z_a[0] = 1'b1;
        op_a[1] = 0;
        op_a[2] = 8; tgt_a[2] = 5; z_a[2] = 1'b0;
        op_a[3] = 15;
        exec_prog("t2");

        // ADD with a 3-cycle-late ack in the read.
        clear_prog();
        op_a[0] = 3; op_a[1] = 15;
        dly.push_back(0); dly.push_back(3); dly.push_back(0);
        exec_prog("t3");

        // Fetch never acked -> timeout; then ack exactly in cycle TIMEOUT.
        clear_prog();
        op_a[0] = 1;
        dly.push_back(255);
        exec_prog("t4a");
        chk("t4a halted", bus.halted_o, 1);
        clear_prog();
        op_a[0] = 1; op_a[1] = 15;
        dly.push_back(TO - 1); dly.push_back(0); dly.push_back(0);
        exec_prog("t4b");

        // Undefined opcode.
        clear_prog();
        op_a[0] = 10; op_a[1] = 15;
        exec_prog("t5");

        // Drop run during a store: the write completes, then IDLE.
        do_reset();
        bus.ir_op_i = 4'd2; bus.run_i = 1'b1;
        step(1); chk("t6 fetch_ld_ir", bus.ld_ir_o, 1);
        step(0);
        step(0); chk("t6 mem_wr_outputs", {bus.mem_req_o, bus.mem_we_o, bus.acc_oe_o, bus.addr_sel_o}, 4'hF);
        bus.run_i = 1'b0;
        step(0); chk("t6 write_held", bus.mem_req_o, 1);
        step(1); chk("t6 write_ack_cycle", bus.mem_we_o, 1);
        step(0); chk("t6 idle_after_write", bus.mem_req_o, 0);
        step(0); chk("t6 idle_stays", bus.mem_req_o, 0);

        // clr pulled low in the middle of a read.
        do_reset();
        bus.ir_op_i = 4'd3; bus.run_i = 1'b1;
        step(1); step(0); step(0);
        chk("t6 rd_alu_op", bus.alu_op_o, 1);
        bus.mem_ack_i = 1'b1; #1;
        chk("t6 rd_en_da_armed", bus.en_da_o, 1);
        clr = 1'b0; #1;
        chk("t6 clr_outputs", {bus.mem_req_o, bus.en_da_o, bus.addr_sel_o, bus.alu_op_o}, 0);
        @(negedge clk);
        bus.mem_ack_i = 1'b0; bus.run_i = 1'b0; clr = 1'b1;
        step(0); chk("t6 idle_after_clr", bus.mem_req_o, 0);
        bus.run_i = 1'b1;
        step(0); chk("t6 fetch_after_idle", {bus.mem_req_o, bus.addr_sel_o}, 2'b10);

        // Random programs with forward-only jumps so every run ends in HALT.
        for (int k = 0; k < 6; k++) begin
            clear_prog();
            for (int i = 0; i < 15; i++) begin
                op_a[i] = $urandom_range(0, 14);
                tgt_a[i] = $urandom_range(i + 1, 15);
                z_a[i] = 1'($urandom_range(0, 1));
            end
            for (int i = 0; i < 40; i++) begin
                int r;
                r = $urandom_range(0, 49);
                dly.push_back((r == 0) ? 255 : r % 4);
            end
            exec_prog($sformatf("rnd%0d", k));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errs);
        $finish;
    end
endmodule
